// File: rtl/alu.sv
// alu: registered 32-bit integer / IEEE-754 single ALU with 64-bit result.
// Ports: a, b operands; opcode select; clk; rst_n async low; out result.
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  opcode,
  input  logic        clk,
  output logic [63:0] out,
  input  logic        rst_n
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_FADD = 5'd5;
  localparam logic [4:0] OP_FSUB = 5'd6;
  localparam logic [4:0] OP_FMUL = 5'd7;
  localparam logic [4:0] OP_XOR  = 5'd8;
  localparam logic [4:0] OP_SLL  = 5'd9;
  localparam logic [4:0] OP_SRL  = 5'd10;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [5:0] lzc49(
    input logic [48:0] v
  );
    logic [5:0] n;
    n = 6'd49;
    for (int i = 0; i < 49; i++)
      if (v[i]) n = 6'(48 - i);
    return n;
  endfunction

  // Significands are carried with 24 extra low bits so any
  // alignment up to 24 places is exact and truncation is a
  // true round-toward-zero.
  function automatic logic [31:0] fp_add(
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic        x_zero, y_zero;
    logic        x_inf, y_inf;
    logic        x_nan, y_nan;
    logic        swap, bs;
    logic [7:0]  be, se, d;
    logic [23:0] bsig, ssig;
    logic [47:0] bx, sx;
    logic [48:0] sum, nrm;
    logic [5:0]  lz;
    logic signed [9:0] e;
    x_zero = x[30:23] == 8'h00;
    y_zero = y[30:23] == 8'h00;
    x_inf  = x[30:23] == 8'hFF && x[22:0] == 23'h0;
    y_inf  = y[30:23] == 8'hFF && y[22:0] == 23'h0;
    x_nan  = x[30:23] == 8'hFF && x[22:0] != 23'h0;
    y_nan  = y[30:23] == 8'hFF && y[22:0] != 23'h0;
    if (x_nan || y_nan)
      return QNAN;
    if (x_inf && y_inf && x[31] != y[31])
      return QNAN;
    if (x_inf)
      return {x[31], 8'hFF, 23'h0};
    if (y_inf)
      return {y[31], 8'hFF, 23'h0};
    if (x_zero && y_zero)
      return 32'h0;
    if (x_zero)
      return y;
    if (y_zero)
      return x;
    swap = y[30:0] > x[30:0];
    bs   = swap ? y[31] : x[31];
    be   = swap ? y[30:23] : x[30:23];
    se   = swap ? x[30:23] : y[30:23];
    bsig = {1'b1, swap ? y[22:0] : x[22:0]};
    ssig = {1'b1, swap ? x[22:0] : y[22:0]};
    d    = be - se;
    bx   = {bsig, 24'h0};
    sx   = (d > 8'd24) ? 48'h0
         : ({ssig, 24'h0} >> d);
    if (x[31] == y[31])
      sum = {1'b0, bx} + {1'b0, sx};
    else
      sum = {1'b0, bx} - {1'b0, sx};
    if (sum == 49'h0)
      return 32'h0;
    lz  = lzc49(sum);
    nrm = sum << lz;
    e   = $signed({2'b0, be}) + 10'sd1
        - $signed({4'b0, lz});
    if (e >= 10'sd255)
      return {bs, 8'hFF, 23'h0};
    if (e <= 10'sd0)
      return 32'h0;
    return {bs, 8'(e), 23'(nrm >> 25)};
  endfunction

  function automatic logic [31:0] fp_mul(
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic        s;
    logic        x_zero, y_zero;
    logic        x_inf, y_inf;
    logic        x_nan, y_nan;
    logic [47:0] p;
    logic [22:0] m;
    logic signed [9:0] e;
    s      = x[31] ^ y[31];
    x_zero = x[30:23] == 8'h00;
    y_zero = y[30:23] == 8'h00;
    x_inf  = x[30:23] == 8'hFF && x[22:0] == 23'h0;
    y_inf  = y[30:23] == 8'hFF && y[22:0] == 23'h0;
    x_nan  = x[30:23] == 8'hFF && x[22:0] != 23'h0;
    y_nan  = y[30:23] == 8'hFF && y[22:0] != 23'h0;
    if (x_nan || y_nan)
      return QNAN;
    if ((x_inf && y_zero) || (y_inf && x_zero))
      return QNAN;
    if (x_inf || y_inf)
      return {s, 8'hFF, 23'h0};
    if (x_zero || y_zero)
      return {s, 31'h0};
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = $signed({2'b0, x[30:23]})
      + $signed({2'b0, y[30:23]})
      - 10'sd127
      + $signed({9'b0, p[47]});
    m = p[47] ? 23'(p >> 24) : 23'(p >> 23);
    if (e >= 10'sd255)
      return {s, 8'hFF, 23'h0};
    if (e <= 10'sd0)
      return 32'h0;
    return {s, 8'(e), m};
  endfunction

  logic [63:0] res;
  logic [32:0] sum33;
  logic [31:0] dif;

  always_comb begin
    sum33 = {1'b0, a} + {1'b0, b};
    dif   = a - b;
    res   = '0;
    unique case (opcode)
      OP_ADD:  res = {31'h0, sum33};
      OP_SUB:  res = {{32{dif[31]}}, dif};
      OP_AND:  res = {32'h0, a & b};
      OP_OR:   res = {32'h0, a | b};
      OP_MUL:  res = 64'(a) * 64'(b);
      OP_FADD: res = {32'h0, fp_add(a, b)};
      OP_FSUB: res = {32'h0,
                      fp_add(a, {~b[31], b[30:0]})};
      OP_FMUL: res = {32'h0, fp_mul(a, b)};
      OP_XOR:  res = {32'h0, a ^ b};
      OP_SLL:  res = {32'h0, a} << b[4:0];
      OP_SRL:  res = {32'h0, a >> b[4:0]};
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= res;
  end

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu plus a chained
// cos(x) Taylor evaluator built from alu instances.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        crst_n;
  logic [31:0] a, b;
  logic [4:0]  opcode;
  logic [63:0] out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [4:0] ADD  = 5'd0;
  localparam logic [4:0] SUB  = 5'd1;
  localparam logic [4:0] AND  = 5'd2;
  localparam logic [4:0] OR   = 5'd3;
  localparam logic [4:0] MUL  = 5'd4;
  localparam logic [4:0] FADD = 5'd5;
  localparam logic [4:0] FSUB = 5'd6;
  localparam logic [4:0] FMUL = 5'd7;
  localparam logic [4:0] XOR  = 5'd8;
  localparam logic [4:0] SLL  = 5'd9;
  localparam logic [4:0] SRL  = 5'd10;

  localparam logic [31:0] CX   = 32'h3EE8_5696;
  localparam logic [31:0] ONE  = 32'h3F80_0000;
  localparam logic [31:0] CM2  = 32'hBF00_0000;
  localparam logic [31:0] C24  = 32'h3D2A_AAAB;
  localparam logic [31:0] CM720 = 32'hBAB6_0B61;
  localparam logic [31:0] C40K = 32'h37D0_0D01;
  localparam logic [31:0] CM10F = 32'hB493_F27E;

  alu dut (
    .a(a), .b(b), .opcode(opcode),
    .clk(clk), .out(out), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  logic [63:0] w_y, w_y2, w_t1, w_y3, w_y4;
  logic [63:0] w_t2, w_s1, w_t3, w_t4, w_y5;
  logic [63:0] w_s2, w_t5, w_u, w_v, w_s;

  alu u_y  (.a(CX), .b(CX), .opcode(FMUL),
            .clk(clk), .out(w_y), .rst_n(crst_n));
  alu u_y2 (.a(w_y[31:0]), .b(w_y[31:0]),
            .opcode(FMUL), .clk(clk), .out(w_y2),
            .rst_n(crst_n));
  alu u_t1 (.a(w_y[31:0]), .b(CM2), .opcode(FMUL),
            .clk(clk), .out(w_t1), .rst_n(crst_n));
  alu u_y3 (.a(w_y2[31:0]), .b(w_y[31:0]),
            .opcode(FMUL), .clk(clk), .out(w_y3),
            .rst_n(crst_n));
  alu u_y4 (.a(w_y2[31:0]), .b(w_y2[31:0]),
            .opcode(FMUL), .clk(clk), .out(w_y4),
            .rst_n(crst_n));
  alu u_t2 (.a(w_y2[31:0]), .b(C24), .opcode(FMUL),
            .clk(clk), .out(w_t2), .rst_n(crst_n));
  alu u_s1 (.a(ONE), .b(w_t1[31:0]), .opcode(FADD),
            .clk(clk), .out(w_s1), .rst_n(crst_n));
  alu u_t3 (.a(w_y3[31:0]), .b(CM720), .opcode(FMUL),
            .clk(clk), .out(w_t3), .rst_n(crst_n));
  alu u_t4 (.a(w_y4[31:0]), .b(C40K), .opcode(FMUL),
            .clk(clk), .out(w_t4), .rst_n(crst_n));
  alu u_y5 (.a(w_y4[31:0]), .b(w_y[31:0]),
            .opcode(FMUL), .clk(clk), .out(w_y5),
            .rst_n(crst_n));
  alu u_s2 (.a(w_s1[31:0]), .b(w_t2[31:0]),
            .opcode(FADD), .clk(clk), .out(w_s2),
            .rst_n(crst_n));
  alu u_t5 (.a(w_y5[31:0]), .b(CM10F), .opcode(FMUL),
            .clk(clk), .out(w_t5), .rst_n(crst_n));
  alu u_u  (.a(w_t3[31:0]), .b(w_t4[31:0]),
            .opcode(FADD), .clk(clk), .out(w_u),
            .rst_n(crst_n));
  alu u_v  (.a(w_u[31:0]), .b(w_t5[31:0]),
            .opcode(FADD), .clk(clk), .out(w_v),
            .rst_n(crst_n));
  alu u_s  (.a(w_s2[31:0]), .b(w_v[31:0]),
            .opcode(FADD), .clk(clk), .out(w_s),
            .rst_n(crst_n));

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic vec(
    input string       tag,
    input logic [4:0]  op,
    input logic [31:0] va,
    input logic [31:0] vb,
    input logic [63:0] exp
  );
    @(negedge clk);
    opcode = op;
    a      = va;
    b      = vb;
    @(posedge clk);
    #1;
    check(tag, out, exp);
  endtask

  real xr, yr, cref;
  int  refm, diff;
  logic [31:0] ref_bits;

  initial begin
    rst_n  = 1'b0;
    crst_n = 1'b0;
    a      = 32'd3;
    b      = 32'd4;
    opcode = ADD;

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", out, 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("add_first", out, 64'd7);

    vec("add_carry", ADD, 32'hFFFF_FFFF, 32'h1,
        64'h1_0000_0000);
    vec("sub_neg", SUB, 32'd1, 32'd2,
        64'hFFFF_FFFF_FFFF_FFFF);
    vec("and", AND, 32'hF0F0_F0F0, 32'hFF00_FF00,
        64'hF000_F000);
    vec("or", OR, 32'hF0F0_F0F0, 32'hFF00_FF00,
        64'hFFF0_FFF0);
    vec("xor", XOR, 32'hF0F0_F0F0, 32'hFF00_FF00,
        64'h0FF0_0FF0);
    vec("mul_max", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        64'hFFFF_FFFE_0000_0001);
    vec("sll_31", SLL, 32'h1, 32'd31,
        64'h8000_0000);
    vec("sll_amt5", SLL, 32'h1, 32'h23, 64'h8);
    vec("srl_31", SRL, 32'h8000_0000, 32'd31, 64'h1);
    vec("undef_31", 5'd31, 32'h1234, 32'h5678, 64'h0);

    vec("fmul_1x2", FMUL, ONE, 32'h4000_0000,
        64'h4000_0000);

    @(negedge clk);
    opcode = MUL;
    a      = 32'h1234_5678;
    b      = 32'h10;
    @(posedge clk);
    #3;
    check("pre_rst", out, 64'h1_2345_6780);
    rst_n = 1'b0;
    #1;
    check("rst_async", out, 64'h0);
    @(posedge clk);
    #1;
    check("rst_held", out, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vec("fmul_h_mh", FMUL, 32'h3F00_0000,
        32'hBF00_0000, 64'hBE80_0000);
    vec("fmul_rtz", FMUL, 32'h3FFF_FFFF,
        32'h3FFF_FFFF, 64'h407F_FFFE);
    vec("fadd_1_mh", FADD, ONE, 32'hBF00_0000,
        64'h3F00_0000);
    vec("fsub_zero", FSUB, ONE, ONE, 64'h0);
    vec("fsub_3_1", FSUB, 32'h4040_0000, ONE,
        64'h4000_0000);
    vec("fsub_d24", FSUB, ONE, 32'h3380_0000,
        64'h3F7F_FFFF);
    vec("fsub_d25", FSUB, ONE, 32'h3300_0000,
        64'h3F80_0000);
    vec("fadd_d30", FADD, ONE, 32'h3080_0000,
        64'h3F80_0000);
    vec("fmul_ovf", FMUL, 32'h7F00_0000,
        32'h4000_0000, 64'h7F80_0000);
    vec("fadd_inf_ninf", FADD, 32'h7F80_0000,
        32'hFF80_0000, 64'h7FC0_0000);
    vec("fmul_subn", FMUL, 32'h0000_0001,
        32'h4000_0000, 64'h0);
    vec("fadd_nan", FADD, 32'h7F80_0001, ONE,
        64'h7FC0_0000);
    vec("fmul_0_inf", FMUL, 32'h8000_0000,
        32'h7F80_0000, 64'h7FC0_0000);
    vec("fsub_inf", FSUB, ONE, 32'h7F80_0000,
        64'hFF80_0000);
    vec("fadd_nz_nz", FADD, 32'h8000_0000,
        32'h8000_0000, 64'h0);
    vec("fmul_nz", FMUL, 32'h8000_0000,
        32'h4000_0000, 64'h8000_0000);
    vec("fmul_unf", FMUL, 32'h0080_0000,
        32'h3F00_0000, 64'h0);

    xr = (1.0 + real'(32'h68_5696) / 8388608.0) / 4.0;
    yr = xr * xr;
    cref = 1.0 - yr / 2.0 + yr * yr / 24.0
         - yr * yr * yr / 720.0
         + yr * yr * yr * yr / 40320.0
         - yr * yr * yr * yr * yr / 3628800.0;
    refm = $rtoi(cref * 16777216.0);
    ref_bits = 32'h3F00_0000 + 32'(refm - 8388608);

    #1;
    check("chain_rst", w_s, 64'h0);
    @(negedge clk);
    crst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 1)
        check("chain_y_exp", {55'h0, w_y[31:23]},
              64'h07C);
      if (k == 6) begin
        diff = int'(w_s[31:0]) - int'(ref_bits);
        if (diff < 0) diff = -diff;
        check("chain_not_early", {63'h0, diff > 8},
              64'h1);
      end
    end
    diff = int'(w_s[31:0]) - int'(ref_bits);
    if (diff < 0) diff = -diff;
    check("cos_sign_exp", {55'h0, w_s[31:23]},
          64'h07E);
    check("cos_upper0", {32'h0, w_s[63:32]}, 64'h0);
    check("cos_ulp_le8", {63'h0, diff <= 8}, 64'h1);
    if (diff > 8)
      $display("cos got %h ref %h", w_s[31:0],
               ref_bits);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
